// File: rtl/text_buffer_ctrl_pkg.sv
// Shared constants, FSM state encoding and the glyph filter for the text line controller.
package text_pkg;

    localparam int NUM_SLOTS  = 10;
    localparam int CHAR_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam logic [CHAR_W-1:0] BLANK_CHAR = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        BKSP  = 2'd2,
        CLEAR = 2'd3
    } state_e;

    // The overlay ROM only holds 7-bit printable glyphs.
    function automatic logic is_printable(input logic [CHAR_W-1:0] code);
        return !code[7] && (code >= 8'h20);
    endfunction

endpackage

// File: rtl/text_buffer_ctrl_if.sv
// Character/command input and display-line output bundle of the text line controller.
interface text_buffer_ctrl_if;
    import text_pkg::*;

    logic [CHAR_W-1:0]           char_in;
    logic                        char_valid;
    logic                        char_ready;
    logic                        cmd_clear;
    logic                        cmd_backspace;
    logic                        vblank;
    logic [NUM_SLOTS*CHAR_W-1:0] letters;
    logic [3:0]                  cursor;
    logic                        scrolled;
    logic                        busy;

    modport master (
        output char_in, char_valid, cmd_clear, cmd_backspace, vblank,
        input  char_ready, letters, cursor, scrolled, busy
    );

    modport slave (
        input  char_in, char_valid, cmd_clear, cmd_backspace, vblank,
        output char_ready, letters, cursor, scrolled, busy
    );

endinterface

// File: rtl/text_buffer_ctrl_char_fifo.sv
// Small show-ahead synchronous FIFO; dout always presents the head entry.
module char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/text_buffer_ctrl.sv
// Buffers decoded characters, edits a shadow line and commits it to the overlay at vblank start.
//
//   state | meaning
//   IDLE  | pick next job: clear, then backspace, then queued char
//   WRITE | place popped char at cursor, or scroll when the line is full
//   BKSP  | blank the slot before the cursor and step back
//   CLEAR | blank the line, home the cursor, flush queued chars
module text_buffer_ctrl
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    text_buffer_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WRITE = WRITE;
    localparam logic [1:0] ST_BKSP  = BKSP;
    localparam logic [1:0] ST_CLEAR = CLEAR;
    localparam logic [3:0] LAST_POS = 4'(NUM_SLOTS);

    logic [1:0]                        state;
    logic [NUM_SLOTS-1:0][CHAR_W-1:0]  shadow;
    logic [NUM_SLOTS-1:0][CHAR_W-1:0]  letters_r;
    logic [3:0]                        cursor_r;
    logic [CHAR_W-1:0]                 wr_char;
    logic                              dirty;
    logic                              clr_pend;
    logic                              bs_pend;
    logic                              vblank_q;
    logic                              vblank_qq;
    logic                              scrolled_r;

    logic              char_ready;
    logic              push;
    logic              pop;
    logic              go_bksp;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CHAR_W-1:0] fifo_head;
    logic              vb_start;
    logic              write_ok;
    logic              bksp_ok;
    logic              edit;

    assign char_ready = !fifo_full && !clr_pend && !bus.cmd_clear;
    assign push       = bus.char_valid && char_ready;
    assign go_bksp    = (state == ST_IDLE) && !clr_pend && bs_pend;
    assign pop        = (state == ST_IDLE) && !clr_pend && !bs_pend && !fifo_empty;
    assign vb_start   = vblank_q && !vblank_qq;
    assign write_ok   = (state == ST_WRITE) && is_printable(wr_char);
    assign bksp_ok    = (state == ST_BKSP) && (cursor_r != 4'd0);
    assign edit       = write_ok || bksp_ok || (state == ST_CLEAR);

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CHAR_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (state == ST_CLEAR),
        .din     (bus.char_in),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            wr_char <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_pend) begin
                        state <= ST_CLEAR;
                    end else if (bs_pend) begin
                        state <= ST_BKSP;
                    end else if (!fifo_empty) begin
                        state   <= ST_WRITE;
                        wr_char <= fifo_head;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A clear supersedes any backspace waiting behind it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_pend <= 1'b0;
            bs_pend  <= 1'b0;
        end else begin
            if (bus.cmd_clear)           clr_pend <= 1'b1;
            else if (state == ST_CLEAR)  clr_pend <= 1'b0;

            if (bus.cmd_clear || clr_pend) bs_pend <= 1'b0;
            else if (bus.cmd_backspace)    bs_pend <= 1'b1;
            else if (go_bksp)              bs_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow     <= {NUM_SLOTS{BLANK_CHAR}};
            cursor_r   <= 4'd0;
            scrolled_r <= 1'b0;
        end else begin
            scrolled_r <= 1'b0;
            if (state == ST_CLEAR) begin
                shadow   <= {NUM_SLOTS{BLANK_CHAR}};
                cursor_r <= 4'd0;
            end else if (write_ok) begin
                if (cursor_r == LAST_POS) begin
                    shadow     <= {wr_char, shadow[NUM_SLOTS-1:1]};
                    scrolled_r <= 1'b1;
                end else begin
                    shadow[cursor_r] <= wr_char;
                    cursor_r         <= cursor_r + 4'd1;
                end
            end else if (bksp_ok) begin
                shadow[cursor_r - 4'd1] <= BLANK_CHAR;
                cursor_r                <= cursor_r - 4'd1;
            end
        end
    end

    // An edit on the commit edge keeps dirty set so it shows at the next vblank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q  <= 1'b0;
            vblank_qq <= 1'b0;
            dirty     <= 1'b0;
            letters_r <= {NUM_SLOTS{BLANK_CHAR}};
        end else begin
            vblank_q  <= bus.vblank;
            vblank_qq <= vblank_q;
            if (vb_start && dirty) letters_r <= shadow;
            if (edit)              dirty <= 1'b1;
            else if (vb_start)     dirty <= 1'b0;
        end
    end

    assign bus.char_ready = char_ready;
    assign bus.letters    = letters_r;
    assign bus.cursor     = cursor_r;
    assign bus.scrolled   = scrolled_r;
    assign bus.busy       = (state != ST_IDLE) || !fifo_empty || dirty;

endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
Sequences decoded Morse characters into the 10-slot text line drawn by the VGA ASCII overlay. It buffers incoming characters and applies write, scroll, backspace and clear edits to a shadow line. It commits the shadow line to the display registers only at vertical-blank start, so the overlay never shows a torn line. It sits between the Morse decoder and the text overlay, driving the overlay's letter0..letter9 inputs.

Parameters:
NUM_SLOTS, 10, character slots on the displayed line
CHAR_W, 8, bits per character code
FIFO_DEPTH, 4, input character queue depth (power of 2)
BLANK_CHAR, 8'h20, fill code for empty slots (space)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
char_in  in  CHAR_W  decoded character code
char_valid  in  1  char_in valid
char_ready  out  1  block can accept char_in this cycle
cmd_clear  in  1  one-cycle pulse: blank the line
cmd_backspace  in  1  one-cycle pulse: delete the last character
vblank  in  1  vertical-blank level from the VGA timing generator
letters  out  NUM_SLOTS*CHAR_W  display line; slot k = bits [8k+7:8k] (letter0 = slot 0, leftmost)
cursor  out  4  next write slot, 0..NUM_SLOTS
scrolled  out  1  one-cycle pulse when a write scrolls the line
busy  out  1  FSM not IDLE, or FIFO non-empty, or commit pending (dirty)

Behaviour:
- Reset (async assert, sync release):
  - letters and shadow all BLANK_CHAR; cursor=0.
  - FIFO empty; FSM=IDLE; dirty=0; pending commands cleared.
  - scrolled=0; busy=0.
- Handshake:
  - A character transfers when char_valid && char_ready.
  - char_ready = !fifo_full && !clr_pend && !cmd_clear.
  - A char offered in the same cycle as cmd_clear is not accepted.
- Filter: a transferred code with bit7 set or below 8'h20 is dropped at WRITE. It makes no shadow change, does not set dirty and does not move cursor. The overlay ROM holds 7-bit printable glyphs only.
- Commands:
  - cmd_clear sets clr_pend, and cmd_backspace sets bs_pend. Both hold until serviced.
  - A clear pending or arriving discards any pending backspace.
- FSM (one edit per cycle), states IDLE, WRITE, BKSP, CLEAR:
  - IDLE, priority order: clr_pend→CLEAR; else bs_pend→BKSP; else FIFO non-empty→WRITE (pop head).
  - WRITE, cursor<NUM_SLOTS: shadow[cursor]=char, cursor+1.
  - WRITE, cursor==NUM_SLOTS: shift shadow left one slot; shadow[NUM_SLOTS-1]=char; cursor unchanged; scrolled pulses.
  - BKSP: if cursor>0, cursor-1 and shadow[cursor-1]=BLANK_CHAR; at cursor 0 it is a no-op (dirty unchanged).
  - CLEAR: shadow all BLANK_CHAR; cursor=0; FIFO flushed; clr_pend cleared.
  - Every state returns to IDLE next cycle. Any shadow change sets dirty.
- Latency:
  - A char accepted at cycle t into an empty FIFO with FSM idle updates the shadow at the edge ending cycle t+2.
  - Sustained throughput is one char per 2 cycles.
- Commit:
  - vblank is registered, and its rising edge gives vb_start.
  - On vb_start with dirty=1, letters<=shadow at that edge and dirty clears.
  - If a shadow edit lands on the same edge, letters takes the pre-edit shadow and dirty stays 1 (set wins).
  - Outside vb_start, letters never changes.
- cursor reflects shadow state, not the committed line.

Decomposition:
- Package text_pkg holds:
  - BLANK_CHAR, NUM_SLOTS and CHAR_W constants;
  - the FSM state enum {IDLE, WRITE, BKSP, CLEAR};
  - an is_printable(code) function.
- Sub-module char_fifo: synchronous FIFO (DEPTH, WIDTH) with push, pop, flush, full and empty, and async active-low reset. It is instantiated once.

Test Plan:
1. Reset, then send "SOS" (8'h53, 8'h4F, 8'h53) with vblank low, then pulse vblank → letters unchanged before vblank; after the rising edge, slots 0-2 = S, O, S, the rest 8'h20, and cursor=3.
2. Send 11 printable chars A..K, then vblank → scrolled pulses once; letters = B..K; cursor=10.
3. From "SOS", pulse cmd_backspace twice, then vblank → letters = "S" followed by blanks, cursor=1. A further 2 backspaces leave cursor=0 with no underflow.
4. Hold char_valid with 5 chars while the FSM is blocked by a pending clear, then fill the FIFO → char_ready=0 when 4 entries are queued. No char is lost or duplicated once ready returns.
5. cmd_clear in the same cycle as char_valid=1 with 8'h41 → the char is not accepted; the line is blank after the next vblank; cursor=0.
6. A shadow edit on the vb_start edge, then 8'h0A and 8'hC1 sent → letters shows the pre-edit line, and the edit appears at the following vblank. 8'h0A and 8'hC1 leave cursor and letters unchanged.
